// File: rtl/bpred_pkg.sv
// Shared definitions for the branch predictor.
//   - 2-bit bimodal counter encodings and saturating step functions
//   - PC -> table index / tag extraction helpers. These work on a wide
//     zero-extended PC and take the index width as an argument, so one
//     package serves every ENTRIES/XLEN combination. Callers size-cast
//     the result down to IDX_W / TAG_W bits.
package bpred_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    // Width of the PC as seen by the helper functions; must exceed XLEN.
    localparam int BP_PC_W = 128;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

    // Index = pc[idx_w+1:2]
    function automatic logic [BP_PC_W-1:0] bp_idx(input logic [BP_PC_W-1:0] pc,
                                                  input int idx_w);
        logic [BP_PC_W-1:0] mask;
        mask = (BP_PC_W'(1) << idx_w) - BP_PC_W'(1);
        return (pc >> 2) & mask;
    endfunction

    // Tag = pc[XLEN-1:idx_w+2]; bits above XLEN are zero after extension.
    function automatic logic [BP_PC_W-1:0] bp_tag(input logic [BP_PC_W-1:0] pc,
                                                  input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter used for the predictor performance counters.
// Ports:
//   clk   - clock, rising edge
//   n_rst - asynchronous active-low reset, clears the count
//   en    - increment request for this cycle
//   cnt   - current count; sticks at all-ones instead of wrapping
module sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped BTB with 2-bit bimodal counters for the RV32 fetch stage.
// Ports:
//   clk, n_rst          - clock and asynchronous active-low reset
//   lookup_pc           - fetch PC; pred_taken/pred_target answer it
//                         combinationally from the current table contents
//   upd_*               - resolved control-flow instruction from EX; tables
//                         are written on the next rising edge
//   mispredict          - combinational redirect/flush request for EX
//   flush_all           - invalidates every entry on the next edge (fence.i)
//   branch_cnt          - saturating count of resolved control-flow ops
//   mispred_cnt         - saturating count of mispredicts
module bpred_btb
    import bpred_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter int         XLEN     = 32,
    parameter int         CNT_W    = 32,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_is_jump,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    input  logic             flush_all,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    // Table state. Kept in flops because the lookup is asynchronous.
    logic             valid_q [ENTRIES];
    logic             valid_d [ENTRIES];
    logic             jmp_q   [ENTRIES];
    logic             jmp_d   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [1:0]       ctr_d   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [TAG_W-1:0] tag_d   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_d   [ENTRIES];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             lookup_hit;
    logic             upd_hit;

    assign lookup_idx = IDX_W'(bp_idx(BP_PC_W'(lookup_pc), IDX_W));
    assign lookup_tag = TAG_W'(bp_tag(BP_PC_W'(lookup_pc), IDX_W));
    assign upd_idx    = IDX_W'(bp_idx(BP_PC_W'(upd_pc), IDX_W));
    assign upd_tag    = TAG_W'(bp_tag(BP_PC_W'(upd_pc), IDX_W));

    // ---------------- lookup ----------------
    assign lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign pred_taken  = lookup_hit && (jmp_q[lookup_idx] || ctr_q[lookup_idx][1]);
    assign pred_target = pred_taken ? tgt_q[lookup_idx] : (lookup_pc + XLEN'(4));

    // ---------------- resolution ----------------
    // A taken branch whose carried target was stale is a mispredict even
    // when the direction guess was right.
    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // ---------------- table next state ----------------
    always_comb begin
        valid_d = valid_q;
        jmp_d   = jmp_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (flush_all) begin
            // Flush takes priority over any same-cycle allocation.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_is_jump) begin
                    ctr_d[upd_idx] = CTR_ST;
                    jmp_d[upd_idx] = 1'b1;
                end else if (upd_taken) begin
                    ctr_d[upd_idx] = ctr_inc(ctr_q[upd_idx]);
                end else begin
                    ctr_d[upd_idx] = ctr_dec(ctr_q[upd_idx]);
                end
                if (upd_taken) begin
                    tgt_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                // Miss on a taken op: claim the slot, evicting any alias.
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_tag;
                tgt_d[upd_idx]   = upd_target;
                jmp_d[upd_idx]   = upd_is_jump;
                ctr_d[upd_idx]   = upd_is_jump ? CTR_ST : CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                jmp_q[i]   <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else begin
            valid_q <= valid_d;
            jmp_q   <= jmp_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    // ---------------- performance counters ----------------
    sat_cnt #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (upd_valid),
        .cnt   (branch_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (mispredict),
        .cnt   (mispred_cnt)
    );

endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
- Parametrised branch predictor (direct-mapped BTB plus 2-bit bimodal counters) for the next-generation RV32 5-stage pipeline.
- Fetch stage looks up PCF combinationally and gets a predicted next PC.
- Execute stage supplies the resolved outcome of each branch/jal/jalr. The block updates its tables, flags mispredicts, and keeps saturating performance counters.
- Replaces today's always-not-taken fetch that flushes D/E on every taken branch.

Parameters:
ENTRIES, 16, BTB/BHT depth; power of 2, >= 2.
XLEN, 32, address/data width.
CNT_W, 32, width of each performance counter.
CTR_INIT, 2'b01, counter value written at reset (weakly not-taken).
(derived) IDX_W = log2(ENTRIES); TAG_W = XLEN-2-IDX_W.

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
lookup_pc  in  XLEN  fetch PC (PCF)
pred_taken  out  1  predict redirect
pred_target  out  XLEN  predicted next PC
upd_valid  in  1  EX holds a resolved, unflushed control-flow instruction
upd_pc  in  XLEN  PC of that instruction (PCE)
upd_is_jump  in  1  jal/jalr (unconditional)
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual target (PC_targetE or ALUResultE)
upd_pred_taken  in  1  prediction carried down the pipe
upd_pred_target  in  XLEN  predicted target carried down the pipe
mispredict  out  1  redirect/flush request, combinational
flush_all  in  1  synchronous table invalidate (fence.i)
branch_cnt  out  CNT_W  resolved control-flow count
mispred_cnt  out  CNT_W  mispredict count

Behaviour:
- Reset is asynchronous and active-low. On reset: all valid bits = 0, all ctr = CTR_INIT, targets/tags don't-care, branch_cnt = mispred_cnt = 0.
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.

Lookup (combinational, zero latency):
- hit = valid[idx] & (tag[idx] == lookup tag).
- pred_taken = hit & (jmp[idx] | ctr[idx][1]).
- pred_target = pred_taken ? tgt[idx] : lookup_pc+4, wrapping mod 2^XLEN.
- Immediately after reset: pred_taken = 0 and pred_target = lookup_pc+4.

mispredict:
- mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_target != upd_target)).
- When upd_valid = 0, mispredict = 0.

Update, registered on rising clk edge when upd_valid = 1:
- Hit, conditional branch: ctr saturating +1 if taken, -1 if not. Limits are 00 and 11 (SNT/WNT/WT/ST).
- Hit, jump: ctr <= 11 and jmp <= 1.
- Hit, taken: tgt <= upd_target.
- Miss, taken: allocate/overwrite the entry. valid = 1, tag, tgt, jmp = upd_is_jump, ctr = jump ? 11 : 10.
- Miss, not taken: no table change.

Counters:
- branch_cnt += 1 on every upd_valid.
- mispred_cnt += 1 on every mispredict.
- Both saturate at all-ones; they never wrap.

Simultaneous events:
- Lookup and update to the same index in one cycle: lookup returns the pre-update contents. The new contents are visible from the next cycle.
- flush_all together with upd_valid: flush wins for the tables (all valid = 0, no allocation). Performance counters still count.
- Reset asserted mid-operation clears state immediately, independent of clk.

Decomposition:
- Package bpred_pkg holds:
  - constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11;
  - functions ctr_inc/ctr_dec (2-bit saturating);
  - functions bp_idx/bp_tag, parametrised by IDX_W.
- One sub-module: sat_cnt (CNT_W, increment enable, asynchronous active-low reset, saturate at max). Instantiate it twice for the performance counters.
- Tables are flop arrays (valid/jmp/ctr/tag/tgt) with no SRAM macro, because lookup must be asynchronous.

Test Plan:
All scenarios use ENTRIES=16 (index = pc[5:2]).
1. Reset, lookup_pc=0x1000_0000 -> pred_taken=0, pred_target=0x1000_0004, branch_cnt=mispred_cnt=0.
2. Update upd_pc=0x1000_0010, taken, target 0x1000_0040, upd_pred_taken=0 -> mispredict=1 that cycle. Next cycle lookup 0x1000_0010 -> pred_taken=1, pred_target=0x1000_0040; branch_cnt=1, mispred_cnt=1.
3. Alias: lookup 0x1000_0050 (same index 4, different tag) -> pred_taken=0, pred_target=0x1000_0054. Then a not-taken update at 0x1000_0050 -> entry for 0x1000_0010 unchanged.
4. Hysteresis on the entry at WT:
   - one not-taken update -> WNT, predicts not-taken;
   - two taken updates -> ST;
   - one not-taken update -> WT, still predicts taken.
5. Jump and flush: jal at 0x1000_0020, target 0x1000_0100 -> ctr=ST, predicts taken. Then flush_all asserted in the same cycle as a taken update -> next cycle every lookup misses, and branch_cnt still increments.
6. Same-cycle update/lookup at 0x1000_0010 that changes the target to 0x1000_0080 -> the same-cycle lookup returns 0x1000_0040, the next cycle returns 0x1000_0080. Separately, with CNT_W=4, 20 mispredicting updates -> both counters hold 15.
